// File: rtl/sha_core.sv
// SHA-256 compression engine: UNROLL rounds per clock, start/done handshake, internal K ROM.
// Define SHA_CORE_DOUBLE_EN to honour dbl (second pass over the padded first digest).
module sha_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dbl,
  input  logic [511:0] M,
  input  logic [255:0] H0,
  output logic         ready,
  output logic         done,
  output logic [255:0] H1,
  output logic [5:0]   round
);

  typedef enum logic [1:0] {StIdle, StRun, StFinal} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] Iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e             state_q, state_d;
  logic [15:0][31:0]  w_q, w_d;     // w_q[0] is W[round]
  logic [7:0][31:0]   h0_q, h0_d;
  logic [7:0][31:0]   v_q, v_d;     // working vars, v_q[0] = a .. v_q[7] = h
  logic [5:0]         round_q, round_d;
  logic [255:0]       h1_q, h1_d;
  logic               done_q, done_d;
  logic               rerun;

  logic [16+UNROLL-1:0][31:0] ext;
  logic [7:0][31:0]           v_rnd;
  logic [31:0]                t1, t2;
  logic [255:0]               digest;
  logic                       load_en;
  logic [511:0]               load_blk;
  logic [255:0]               load_h;

  // Schedule extension and UNROLL chained rounds for this cycle.
  always_comb begin
    ext        = '0;
    ext[15:0]  = w_q;
    for (int j = 0; j < UNROLL; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
    v_rnd = v_q;
    t1    = '0;
    t2    = '0;
    for (int u = 0; u < UNROLL; u++) begin
      t1 = v_rnd[7] + bsig1(v_rnd[4]) + ((v_rnd[4] & v_rnd[5]) ^ (~v_rnd[4] & v_rnd[6]))
         + K[round_q + 6'(u)] + ext[u];
      t2 = bsig0(v_rnd[0]) + ((v_rnd[0] & v_rnd[1]) ^ (v_rnd[0] & v_rnd[2]) ^
                              (v_rnd[1] & v_rnd[2]));
      v_rnd[7] = v_rnd[6];
      v_rnd[6] = v_rnd[5];
      v_rnd[5] = v_rnd[4];
      v_rnd[4] = v_rnd[3] + t1;
      v_rnd[3] = v_rnd[2];
      v_rnd[2] = v_rnd[1];
      v_rnd[1] = v_rnd[0];
      v_rnd[0] = t1 + t2;
    end
  end

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) begin
      digest[255-32*i -: 32] = v_q[i] + h0_q[i];
    end
  end

`ifdef SHA_CORE_DOUBLE_EN
  logic dbl_q, second_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbl_q    <= 1'b0;
      second_q <= 1'b0;
    end else if (ready && start) begin
      dbl_q    <= dbl;
      second_q <= 1'b0;
    end else if (state_q == StFinal && rerun) begin
      second_q <= 1'b1;
    end
  end

  assign rerun = dbl_q & ~second_q;
`else
  logic unused_dbl;
  assign unused_dbl = dbl;
  assign rerun      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h0_d     = h0_q;
    v_d      = v_q;
    round_d  = round_q;
    h1_d     = h1_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_blk = M;
    load_h   = H0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_en = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        w_d     = ext[UNROLL +: 16];
        v_d     = v_rnd;
        round_d = round_q + 6'(UNROLL);
        if (round_q == 6'(64 - UNROLL)) state_d = StFinal;
      end
      StFinal: begin
        if (rerun) begin
          // Second pass hashes the 32-byte first digest as a single padded block.
          load_en  = 1'b1;
          load_blk = {digest, 32'h8000_0000, 192'd0, 32'h0000_0100};
          load_h   = Iv;
          state_d  = StRun;
        end else begin
          h1_d    = digest;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_en) begin
      for (int i = 0; i < 16; i++) w_d[i] = load_blk[511-32*i -: 32];
      for (int i = 0; i < 8; i++) begin
        h0_d[i] = load_h[255-32*i -: 32];
        v_d[i]  = load_h[255-32*i -: 32];
      end
      round_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      w_q     <= '0;
      h0_q    <= '0;
      v_q     <= '0;
      round_q <= '0;
      h1_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h0_q    <= h0_d;
      v_q     <= v_d;
      round_q <= round_d;
      h1_q    <= h1_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = done_q;
  assign H1    = h1_q;
  assign round = round_q;

endmodule
